simplebus_mem_responder: RTL and testbench
==========================================

# simplebus_mem_responder

Single-outstanding SimpleBus responder with an internal 64-bit-wide memory array, used as the memory-side model behind the cache under test. It accepts requests on the SimpleBus `req` channel, performs byte-masked writes or single/burst reads after a programmable latency, and returns responses on the `resp` channel with the request's `user` field echoed. It is the responder end of the same SimpleBus protocol the cache drives as initiator.

## Interface
Parameters:
- `MEM_WORDS`, 1024: number of 64-bit words; power of two.
- `LATENCY`, 2: cycles from request acceptance to first response beat; ≥1.
- `BURST_LEN`, 4: beats per read burst; line size = 8·BURST_LEN bytes; power of two.

Ports:
- `clk` input 1: the single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_ready` output 1: request accepted when `req_valid && req_ready`.
- `req_valid` input 1
- `req_bits_addr` input 32: byte address; bits [2:0] ignored.
- `req_bits_size` input 3: ignored; `wmask` governs writes.
- `req_bits_cmd` input 4: 0000 read, 0001 write, 0010 readBurst, 0011 writeBurst, 0111 writeLast, 1000 probe.
- `req_bits_wmask` input 8: byte enables, bit i → byte i.
- `req_bits_wdata` input 64
- `req_bits_user` input 16: latched, echoed on response.
- `resp_ready` input 1
- `resp_valid` output 1
- `resp_bits_cmd` output 4: 0000 read (non-last), 0110 readLast, 0101 writeResp, 1000 probeMiss.
- `resp_bits_rdata` output 64
- `resp_bits_user` output 16

## Operation
- States: IDLE, WBURST, WAIT, RESP.
- Word index = `addr[3 +: log2(MEM_WORDS)]`; higher bits ignored (aliasing).
- IDLE: `req_ready`=1. On accept, latch addr, cmd, user:
  - read 0000 → WAIT, one beat, cmd 0110.
  - readBurst 0010 → WAIT, BURST_LEN beats.
  - write 0001 → write masked bytes in the acceptance cycle → WAIT, one 0101 beat, rdata 0.
  - writeBurst 0011 → write beat 0 → WBURST.
  - writeLast 0111 received in IDLE → treated as single write.
  - probe 1000 → WAIT, one 1000 beat, rdata 0, no memory access.
  - any other cmd → WAIT, one 0110 beat, rdata 0, no memory access.
- WBURST: `req_ready`=1; each accepted beat is written at the next word in the line. Beat cmd 0011 stays in WBURST; any other cmd is written and treated as last → WAIT, one 0101 beat. `user` is taken from the first beat.
- Line-wrap addressing, critical word first: beat i word = {line base, (start word + i) mod BURST_LEN}. Applies to both read and write bursts; more than BURST_LEN write beats keep wrapping.
- WAIT: count LATENCY−1 cycles, then RESP.
- RESP: `resp_valid`=1; bits stable until `resp_ready`. Read beats: cmd 0000 except the final beat, which is 0110. On the final beat fire → IDLE.
- Memory contents are not cleared by `rst`.

## Timing
- During `rst`: `req_ready`=0, `resp_valid`=0, `resp_bits_*`=0. State → IDLE on the next edge, so `req_ready`=1 in the first cycle after `rst` deasserts.
- Request accepted at edge T (last write beat for bursts) → `resp_valid` first high in cycle T+LATENCY.
- Burst read: after each beat handshake, the next beat is valid in the following cycle (no bubbles while `resp_ready`=1).
- Read data reflects all writes accepted before the read's acceptance.
- `req_ready`=0 in WAIT/RESP, including the cycle of the final response fire. Next accept is no earlier than the cycle after. Minimum single-op period = LATENCY+1 cycles.
- `resp_valid` drops the cycle after the final beat fires unless a new response is due. It never drops without a handshake, except on reset.
- `rst` mid-operation: abort at that edge; pending responses are discarded. Burst beats already written remain in memory.

## Test plan
- Single write/read: write addr 0x100, wdata 0x1122334455667788, wmask 0xFF → writeResp 0101 at T+2, user echoed. Read 0x100 → 0110 with 0x1122334455667788.
- Byte mask: write 0x100 with wdata 0xAAAA…AA, wmask 0x0F, then read → 0x11223344AAAAAAAA.
- Wrapped read burst: preload words 0x200/0x208/0x210/0x218 = 0,1,2,3. readBurst at 0x210 → beats 2,3,0,1 with cmds 0000,0000,0000,0110.
- Write burst then read-back: beats 0011,0011,0011,0111 at 0x300 with data A,B,C,D → single 0101 at last-beat T+2. readBurst at 0x300 → A,B,C,D.
- Backpressure: hold `resp_ready`=0 for 5 cycles mid-burst → `resp_valid`, cmd, rdata, user stable; `req_ready`=0 throughout.
- Reset mid-burst: assert `rst` during beat 2 of a read burst → `resp_valid`=0 next cycle, `req_ready`=1 after release, earlier-written memory intact. Probe 1000 → 1000, rdata 0.

Source files
------------

// File: rtl/simplebus_mem_responder_if.sv
// SimpleBus request/response channel bundle between an initiator (master)
// and a memory-side responder (slave).
interface simplebus_mem_responder_if;
  logic        req_ready;
  logic        req_valid;
  logic [31:0] req_bits_addr;
  logic [2:0]  req_bits_size;
  logic [3:0]  req_bits_cmd;
  logic [7:0]  req_bits_wmask;
  logic [63:0] req_bits_wdata;
  logic [15:0] req_bits_user;
  logic        resp_ready;
  logic        resp_valid;
  logic [3:0]  resp_bits_cmd;
  logic [63:0] resp_bits_rdata;
  logic [15:0] resp_bits_user;

  modport master (
    input  req_ready,
    output req_valid, req_bits_addr, req_bits_size, req_bits_cmd,
    output req_bits_wmask, req_bits_wdata, req_bits_user,
    output resp_ready,
    input  resp_valid, resp_bits_cmd, resp_bits_rdata, resp_bits_user
  );

  modport slave (
    output req_ready,
    input  req_valid, req_bits_addr, req_bits_size, req_bits_cmd,
    input  req_bits_wmask, req_bits_wdata, req_bits_user,
    input  resp_ready,
    output resp_valid, resp_bits_cmd, resp_bits_rdata, resp_bits_user
  );
endinterface

// File: rtl/simplebus_mem_responder.sv
// Single-outstanding SimpleBus memory responder: byte-masked writes, wrapped
// critical-word-first bursts, programmable response latency.
module simplebus_mem_responder #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned BURST_LEN = 4
) (
  input logic                      clk,
  input logic                      rst,
  simplebus_mem_responder_if.slave bus
);
  localparam int unsigned AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CW        = $clog2(BURST_LEN + 1);
  localparam int unsigned WW        = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam int unsigned WAIT_LAST = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam logic [AW-1:0] OFF_MASK = AW'(BURST_LEN - 1);

  localparam logic [3:0] CMD_READ   = 4'b0000;
  localparam logic [3:0] CMD_WRITE  = 4'b0001;
  localparam logic [3:0] CMD_RBURST = 4'b0010;
  localparam logic [3:0] CMD_WBURST = 4'b0011;
  localparam logic [3:0] CMD_WLAST  = 4'b0111;
  localparam logic [3:0] CMD_PROBE  = 4'b1000;
  localparam logic [3:0] RSP_RLAST  = 4'b0110;
  localparam logic [3:0] RSP_WRESP  = 4'b0101;
  localparam logic [3:0] RSP_PMISS  = 4'b1000;

  typedef enum logic [1:0] {S_IDLE, S_WBURST, S_WAIT, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] word_q, word_d;
  logic [CW-1:0] left_q, left_d;
  logic [3:0]    final_q, final_d;
  logic          rd_q, rd_d;
  logic [WW-1:0] cnt_q, cnt_d;
  logic [15:0]   user_q, user_d;
  logic          rdy_q, rdy_d;
  logic          vld_q, vld_d;
  logic [3:0]    rcmd_q, rcmd_d;
  logic [63:0]   rdata_q, rdata_d;

  logic [63:0]   mem [MEM_WORDS];
  logic          req_fire, resp_fire, go, load, we;
  logic [AW-1:0] waddr, req_idx;
  logic          unused;

  assign req_idx   = bus.req_bits_addr[3 +: AW];
  assign req_fire  = bus.req_valid & rdy_q & ~rst;
  assign resp_fire = bus.resp_ready & vld_q & ~rst;
  assign unused    = ^{bus.req_bits_size, bus.req_bits_addr[2:0], bus.req_bits_addr[31:3+AW]};

  // Reset forces the visible handshake and payload to idle immediately.
  assign bus.req_ready       = rdy_q & ~rst;
  assign bus.resp_valid      = vld_q & ~rst;
  assign bus.resp_bits_cmd   = rst ? 4'b0 : rcmd_q;
  assign bus.resp_bits_rdata = rst ? 64'b0 : rdata_q;
  assign bus.resp_bits_user  = rst ? 16'b0 : user_q;

  // Next word within the line, wrapping at the line boundary.
  function automatic logic [AW-1:0] wrap_next(input logic [AW-1:0] w);
    return (w & ~OFF_MASK) | ((w + AW'(1)) & OFF_MASK);
  endfunction

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    left_d  = left_q;
    final_d = final_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    user_d  = user_q;
    vld_d   = vld_q;
    rcmd_d  = rcmd_q;
    rdata_d = rdata_q;
    go      = 1'b0;
    load    = 1'b0;
    we      = 1'b0;
    waddr   = word_q;

    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          word_d  = req_idx;
          user_d  = bus.req_bits_user;
          left_d  = CW'(1);
          rd_d    = 1'b0;
          final_d = RSP_RLAST;
          go      = 1'b1;
          case (bus.req_bits_cmd)
            CMD_READ:   rd_d = 1'b1;
            CMD_RBURST: begin
              rd_d   = 1'b1;
              left_d = CW'(BURST_LEN);
            end
            CMD_WRITE, CMD_WLAST: begin
              we      = 1'b1;
              waddr   = req_idx;
              final_d = RSP_WRESP;
            end
            CMD_WBURST: begin
              we      = 1'b1;
              waddr   = req_idx;
              go      = 1'b0;
              state_d = S_WBURST;
            end
            CMD_PROBE:  final_d = RSP_PMISS;
            default:    ;
          endcase
        end
      end
      S_WBURST: begin
        if (req_fire) begin
          we     = 1'b1;
          waddr  = wrap_next(word_q);
          word_d = wrap_next(word_q);
          if (bus.req_bits_cmd != CMD_WBURST) begin
            final_d = RSP_WRESP;
            go      = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == WW'(WAIT_LAST)) begin
          state_d = S_RESP;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q + WW'(1);
        end
      end
      S_RESP: begin
        if (resp_fire) begin
          if (left_q == CW'(1)) begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
          end else begin
            word_d = wrap_next(word_q);
            left_d = left_q - CW'(1);
            load   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go) begin
      cnt_d = '0;
      if (LATENCY > 1) begin
        state_d = S_WAIT;
      end else begin
        state_d = S_RESP;
        load    = 1'b1;
      end
    end

    // Present the beat at word_d; only the final beat carries the terminal cmd.
    if (load) begin
      vld_d   = 1'b1;
      rcmd_d  = (left_d == CW'(1)) ? final_d : CMD_READ;
      rdata_d = rd_d ? mem[word_d] : 64'b0;
    end

    rdy_d = (state_d == S_IDLE) || (state_d == S_WBURST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      left_q  <= '0;
      final_q <= '0;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
      user_q  <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      rcmd_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      left_q  <= left_d;
      final_q <= final_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      user_q  <= user_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      rcmd_q  <= rcmd_d;
      rdata_q <= rdata_d;
    end
  end

  // Byte-masked storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.req_bits_wmask[b]) mem[waddr][8*b +: 8] <= bus.req_bits_wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_simplebus_mem_responder.sv
// Bench for simplebus_mem_responder: directed scenarios plus randomized traffic
// compared against a word-array reference model.
module tb_simplebus_mem_responder;
  localparam int unsigned MEM_WORDS = 1024;
  localparam int unsigned LATENCY   = 2;
  localparam int unsigned BURST_LEN = 4;

  localparam logic [3:0] C_READ   = 4'b0000;
  localparam logic [3:0] C_WRITE  = 4'b0001;
  localparam logic [3:0] C_RBURST = 4'b0010;
  localparam logic [3:0] C_WBURST = 4'b0011;
  localparam logic [3:0] C_WLAST  = 4'b0111;
  localparam logic [3:0] C_PROBE  = 4'b1000;
  localparam logic [3:0] R_RLAST  = 4'b0110;
  localparam logic [3:0] R_WRESP  = 4'b0101;
  localparam logic [3:0] R_PMISS  = 4'b1000;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [63:0] rdata;
    logic [15:0] user;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  simplebus_mem_responder_if bus ();
  simplebus_mem_responder #(
    .MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          errors = 0;
  int          checks = 0;
  logic [63:0] mm [MEM_WORDS];
  beat_t       exp_q [$];
  logic [63:0] wb_data [8];
  logic [7:0]  wb_mask [8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 3) % MEM_WORDS);
  endfunction

  function automatic int burst_word(input int start, input int i);
    return (start / BURST_LEN) * BURST_LEN + (start + i) % BURST_LEN;
  endfunction

  task automatic model_write(input int w, input logic [7:0] m, input logic [63:0] d);
    for (int b = 0; b < 8; b++) if (m[b]) mm[w][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic push(input logic [3:0] c, input logic [63:0] d, input logic [15:0] u);
    beat_t b;
    b.cmd = c; b.rdata = d; b.user = u;
    exp_q.push_back(b);
  endtask

  // Drive one request beat from a negedge; returns at the negedge after acceptance.
  task automatic do_req(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [7:0] m, input logic [63:0] d, input logic [15:0] u);
    int n;
    n = 0;
    bus.req_valid      = 1'b1;
    bus.req_bits_cmd   = c;
    bus.req_bits_addr  = a;
    bus.req_bits_size  = 3'($urandom);
    bus.req_bits_wmask = m;
    bus.req_bits_wdata = d;
    bus.req_bits_user  = u;
    while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk({tag, " accept"}, 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Consume the expected beats; optional 5-cycle stall or reset at a given beat.
  task automatic collect(input string tag, input int stall_at, input int abort_at);
    int    n;
    int    k;
    beat_t e;
    n = 1;
    k = 0;
    while (bus.resp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk({tag, " latency"}, 64'(n), 64'(LATENCY));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, " valid"}, 64'(bus.resp_valid), 64'd1);
      chk({tag, " cmd"}, 64'(bus.resp_bits_cmd), 64'(e.cmd));
      chk({tag, " rdata"}, bus.resp_bits_rdata, e.rdata);
      chk({tag, " user"}, 64'(bus.resp_bits_user), 64'(e.user));
      chk({tag, " req_ready busy"}, 64'(bus.req_ready), 64'd0);
      if (k == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk({tag, " valid in rst"}, 64'(bus.resp_valid), 64'd0);
        chk({tag, " ready in rst"}, 64'(bus.req_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk({tag, " ready after rst"}, 64'(bus.req_ready), 64'd1);
        chk({tag, " valid after rst"}, 64'(bus.resp_valid), 64'd0);
        exp_q.delete();
        return;
      end
      if (k == stall_at) begin
        bus.resp_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk({tag, " stall valid"}, 64'(bus.resp_valid), 64'd1);
          chk({tag, " stall cmd"}, 64'(bus.resp_bits_cmd), 64'(e.cmd));
          chk({tag, " stall rdata"}, bus.resp_bits_rdata, e.rdata);
          chk({tag, " stall user"}, 64'(bus.resp_bits_user), 64'(e.user));
          chk({tag, " stall req_ready"}, 64'(bus.req_ready), 64'd0);
        end
        bus.resp_ready = 1'b1;
      end
      @(negedge clk);
      k++;
    end
    chk({tag, " valid drop"}, 64'(bus.resp_valid), 64'd0);
    chk({tag, " ready back"}, 64'(bus.req_ready), 64'd1);
  endtask

  task automatic single(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [7:0] m, input logic [63:0] d, input logic [15:0] u,
                        input int stall_at, input int abort_at);
    int w;
    w = widx(a);
    case (c)
      C_READ: push(R_RLAST, mm[w], u);
      C_WRITE, C_WLAST: begin
        model_write(w, m, d);
        push(R_WRESP, 64'd0, u);
      end
      C_RBURST:
        for (int i = 0; i < BURST_LEN; i++)
          push((i == BURST_LEN - 1) ? R_RLAST : C_READ, mm[burst_word(w, i)], u);
      C_PROBE: push(R_PMISS, 64'd0, u);
      default: push(R_RLAST, 64'd0, u);
    endcase
    do_req(tag, c, a, m, d, u);
    collect(tag, stall_at, abort_at);
  endtask

  // Write burst of len>=2 beats from wb_data/wb_mask; later beats carry junk user.
  task automatic wburst(input string tag, input logic [31:0] a, input int len,
                        input logic [15:0] u, input logic [3:0] last_c);
    int w;
    w = widx(a);
    for (int i = 0; i < len; i++) begin
      model_write(burst_word(w, i), wb_mask[i], wb_data[i]);
      do_req(tag, (i == len - 1) ? last_c : C_WBURST, a, wb_mask[i], wb_data[i],
             (i == 0) ? u : 16'($urandom));
    end
    push(R_WRESP, 64'd0, u);
    collect(tag, -1, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int          op;
    int          stall;
    int          len;
    logic [31:0] a;
    logic [3:0]  odd_cmds [5];
    odd_cmds = '{4'h4, 4'h5, 4'h6, 4'h9, 4'hF};

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_bits_cmd = 4'b0; bus.req_bits_addr = 32'b0; bus.req_bits_size = 3'b0;
    bus.req_bits_wmask = 8'b0; bus.req_bits_wdata = 64'b0; bus.req_bits_user = 16'b0;
    bus.resp_ready = 1'b1;

    @(negedge clk);
    chk("rst req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst resp_cmd", 64'(bus.resp_bits_cmd), 64'd0);
    chk("rst resp_rdata", bus.resp_bits_rdata, 64'd0);
    chk("rst resp_user", 64'(bus.resp_bits_user), 64'd0);
    repeat (2) @(negedge clk);
    chk("rst req_ready held", 64'(bus.req_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst req_ready", 64'(bus.req_ready), 64'd1);

    for (int w = 0; w < 128; w++)
      single("preload", C_WRITE, 32'(w * 8), 8'hFF, {$urandom, $urandom}, 16'($urandom), -1, -1);

    single("wr 0x100", C_WRITE, 32'h100, 8'hFF, 64'h1122334455667788, 16'hBEEF, -1, -1);
    single("rd 0x100", C_READ, 32'h100, 8'h00, 64'd0, 16'h1234, -1, -1);
    single("mask wr", C_WRITE, 32'h100, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 16'h0F0F, -1, -1);
    chk("mask model", mm[32], 64'h11223344AAAAAAAA);
    single("mask rd", C_READ, 32'h100, 8'h00, 64'd0, 16'h5A5A, -1, -1);
    single("alias rd", C_READ, 32'h2100, 8'h00, 64'd0, 16'h7777, -1, -1);
    single("wlast idle", C_WLAST, 32'h108, 8'hF0, 64'hCAFEF00DDEADBEEF, 16'h0108, -1, -1);

    for (int i = 0; i < 4; i++)
      single("preload 0x200", C_WRITE, 32'(32'h200 + i * 8), 8'hFF, 64'(i), 16'(i), -1, -1);
    single("rburst 0x210", C_RBURST, 32'h210, 8'h00, 64'd0, 16'hA210, -1, -1);

    wb_data[0] = 64'hAAAA_0000_0000_000A; wb_data[1] = 64'hBBBB_0000_0000_000B;
    wb_data[2] = 64'hCCCC_0000_0000_000C; wb_data[3] = 64'hDDDD_0000_0000_000D;
    for (int i = 0; i < 8; i++) wb_mask[i] = 8'hFF;
    wburst("wburst 0x300", 32'h300, 4, 16'h0300, C_WLAST);
    single("rburst 0x300", C_RBURST, 32'h300, 8'h00, 64'd0, 16'hB300, -1, -1);
    single("backpressure", C_RBURST, 32'h300, 8'h00, 64'd0, 16'hBACC, 1, -1);

    single("rst mid-burst", C_RBURST, 32'h200, 8'h00, 64'd0, 16'hDEAD, -1, 2);
    single("rd after rst", C_READ, 32'h100, 8'h00, 64'd0, 16'h4321, -1, -1);
    single("probe", C_PROBE, 32'h100, 8'hFF, 64'hFFFF, 16'h9999, -1, -1);
    single("odd cmd", 4'h4, 32'h100, 8'hFF, 64'h1234, 16'h0404, -1, -1);
    single("rd odd intact", C_READ, 32'h100, 8'h00, 64'd0, 16'h0405, -1, -1);

    for (int t = 0; t < 80; t++) begin
      op    = int'($urandom_range(0, 6));
      a     = (32'($urandom_range(0, 127)) << 3) | 32'($urandom_range(0, 7))
            | (32'($urandom_range(0, 3)) << 13);
      stall = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, BURST_LEN - 1)) : -1;
      case (op)
        0: single("rnd read", C_READ, a, 8'h00, 64'd0, 16'($urandom), stall, -1);
        1: single("rnd rburst", C_RBURST, a, 8'h00, 64'd0, 16'($urandom), stall, -1);
        2: single("rnd write", C_WRITE, a, 8'($urandom), {$urandom, $urandom}, 16'($urandom), stall, -1);
        3: single("rnd wlast", C_WLAST, a, 8'($urandom), {$urandom, $urandom}, 16'($urandom), stall, -1);
        4: begin
          len = int'($urandom_range(2, 6));
          for (int i = 0; i < 8; i++) begin
            wb_data[i] = {$urandom, $urandom};
            wb_mask[i] = 8'($urandom);
          end
          wburst("rnd wburst", a, len, 16'($urandom), ($urandom_range(0, 3) == 0) ? C_WRITE : C_WLAST);
        end
        5: single("rnd probe", C_PROBE, a, 8'($urandom), {$urandom, $urandom}, 16'($urandom), stall, -1);
        default: single("rnd other", odd_cmds[$urandom_range(0, 4)], a, 8'hFF, {$urandom, $urandom},
                        16'($urandom), stall, -1);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
